// File: rtl/cntdown_timer.sv
// Programmable down-counting timer with prescaler, one-shot or periodic reload.
// Produces a one-cycle done pulse on expiry; busy mirrors the RUN state.
//
// state | meaning
// IDLE  | not counting, cnt_out held, waits for load
// RUN   | counting down at the prescaled tick rate
module cntdown_timer #(
  parameter int WIDTH     = 5,
  parameter int PRE_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enab,
  input  logic                 load,
  input  logic [WIDTH-1:0]     cnt_in,
  input  logic                 reload_mode,
  input  logic [PRE_WIDTH-1:0] pre_div,
  output logic [WIDTH-1:0]     cnt_out,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     reload_q, reload_d;
  logic [PRE_WIDTH-1:0] pre_cnt_q, pre_cnt_d;
  logic                 done_q, done_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      reload_q  <= '0;
      pre_cnt_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      reload_q  <= reload_d;
      pre_cnt_q <= pre_cnt_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    reload_d  = reload_q;
    pre_cnt_d = pre_cnt_q;
    done_d    = 1'b0;
    if (load) begin
      cnt_d     = cnt_in;
      reload_d  = cnt_in;
      pre_cnt_d = '0;
      state_d   = (cnt_in != '0) ? RUN : IDLE;
    end else if (state_q == RUN && enab) begin
      // >= rather than == so a pre_div shrunk mid-run ticks at once instead of wrapping
      if (pre_cnt_q < pre_div) begin
        pre_cnt_d = pre_cnt_q + PRE_WIDTH'(1);
      end else begin
        pre_cnt_d = '0;
        if (cnt_q > WIDTH'(1)) begin
          cnt_d = cnt_q - WIDTH'(1);
        end else begin
          done_d = 1'b1;
          if (reload_mode) begin
            cnt_d = reload_q;
          end else begin
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
      end
    end
  end

  assign cnt_out = cnt_q;
  assign busy    = (state_q == RUN);
  assign done    = done_q;

endmodule

// File: tb/tb_cntdown_timer.sv
// Bench for cntdown_timer: directed corner cases plus random stimulus against
// a cycle-level reference model built from remaining-ticks arithmetic.
module tb_cntdown_timer;

  localparam int WIDTH     = 5;
  localparam int PRE_WIDTH = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 enab;
  logic                 load;
  logic [WIDTH-1:0]     cnt_in;
  logic                 reload_mode;
  logic [PRE_WIDTH-1:0] pre_div;
  logic [WIDTH-1:0]     cnt_out;
  logic                 busy;
  logic                 done;

  int checks   = 0;
  int failures = 0;

  // reference model: plain integers
  int m_cnt, m_rel, m_phase, m_done;
  bit m_run;

  cntdown_timer #(.WIDTH(WIDTH), .PRE_WIDTH(PRE_WIDTH)) dut (
    .clk(clk), .rst(rst), .enab(enab), .load(load), .cnt_in(cnt_in),
    .reload_mode(reload_mode), .pre_div(pre_div),
    .cnt_out(cnt_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_cnt = 0; m_rel = 0; m_phase = 0; m_done = 0; m_run = 0;
  endtask

  task automatic model_edge();
    if (rst) begin
      model_clear();
      return;
    end
    m_done = 0;
    if (load) begin
      m_cnt = int'(cnt_in); m_rel = int'(cnt_in); m_phase = 0;
      m_run = (cnt_in != 0);
    end else if (m_run && enab) begin
      if (m_phase < int'(pre_div)) m_phase = m_phase + 1;
      else begin
        m_phase = 0;
        if (m_cnt > 1) m_cnt = m_cnt - 1;
        else begin
          m_done = 1;
          if (reload_mode) m_cnt = m_rel;
          else begin m_cnt = 0; m_run = 0; end
        end
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".cnt"},  32'(cnt_out), 32'(m_cnt));
    chk({tag, ".busy"}, 32'(busy),    32'(m_run));
    chk({tag, ".done"}, 32'(done),    32'(m_done));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic idle_inputs();
    rst = 0; load = 0; enab = 1; cnt_in = '0; reload_mode = 0; pre_div = '0;
  endtask

  // load N and count edges until done; expiry edge must be N*(pd+1)
  task automatic latency_run(input int n, input int pd);
    int k;
    idle_inputs(); pre_div = PRE_WIDTH'(pd); load = 1; cnt_in = WIDTH'(n);
    step("lat_load");
    load = 0;
    k = 0;
    for (int i = 1; i <= 600; i++) begin
      step("lat_run");
      if (done) begin k = i; break; end
    end
    chk("latency", 32'(k), 32'(n * (pd + 1)));
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    model_clear();
    @(negedge clk);
    check_outputs("reset");
    step("reset_hold");
    rst = 0;
    step("idle_after_reset");

    // one-shot and prescaled latency
    latency_run(5, 0);
    step("oneshot_after");
    chk("oneshot_zero", 32'(cnt_out), 32'd0);
    latency_run(2, 2);
    latency_run(31, 1);

    // periodic: 3,2,1,3,... with done every 3 cycles
    idle_inputs(); reload_mode = 1; load = 1; cnt_in = 5'd3;
    step("per_load");
    load = 0;
    for (int i = 0; i < 9; i++) begin
      step("periodic");
      chk("per_seq", 32'(cnt_out), 32'(3 - ((i + 1) % 3)));
      chk("per_done", 32'(done), 32'(((i + 1) % 3) == 0));
    end

    // pre_div shrinks from 3 to 0 while phase is 2 -> immediate tick
    idle_inputs(); pre_div = 4'd3; load = 1; cnt_in = 5'd6;
    step("shrink_load");
    load = 0;
    step("shrink_p1"); step("shrink_p2");
    pre_div = 4'd0;
    step("shrink_tick");
    chk("shrink_cnt", 32'(cnt_out), 32'd5);

    // pause: load 4, 2 edges, enab low 4 cycles, expiry on edge 8
    idle_inputs(); load = 1; cnt_in = 5'd4;
    step("pause_load");
    load = 0;
    step("pause_a"); step("pause_b");
    enab = 0;
    for (int i = 0; i < 4; i++) step("paused");
    chk("pause_hold", 32'(cnt_out), 32'd2);
    enab = 1;
    step("pause_c");
    step("pause_d");
    chk("pause_done", 32'(done), 32'd1);

    // load 0, load 31 while at 1, load on expiry edge
    idle_inputs(); load = 1; cnt_in = 5'd0;
    step("load0");
    chk("load0_busy", 32'(busy), 32'd0);
    cnt_in = 5'd1;
    step("load1");
    cnt_in = 5'd31;
    step("load_on_expiry");
    chk("loadexp_done", 32'(done), 32'd0);
    chk("loadexp_cnt", 32'(cnt_out), 32'd31);

    // async reset mid-cycle while counting at 7
    idle_inputs(); load = 1; cnt_in = 5'd9;
    step("ar_load");
    load = 0;
    step("ar_a"); step("ar_b");
    chk("ar_pre", 32'(cnt_out), 32'd7);
    #2 rst = 1;
    #1;
    model_clear();
    check_outputs("async_rst");
    rst = 0;
    step("ar_idle");
    step("ar_idle2");

    // random stimulus against the model
    for (int i = 0; i < 3000; i++) begin
      rst         = ($urandom_range(0, 199) == 0);
      load        = ($urandom_range(0, 11) == 0);
      cnt_in      = WIDTH'($urandom_range(0, 31));
      enab        = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 19) == 0) reload_mode = $urandom_range(0, 1);
      if ($urandom_range(0, 9) == 0) pre_div = PRE_WIDTH'($urandom_range(0, 4));
      step("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
